prio_enc_pend: RTL and testbench

Parametrised, registered successor to the 4-to-2 priority encoder. Request events on `N` lines are captured into a sticky pending register. The block then emits one encoded index at a time through a valid/ready output stage, clearing each pending bit as its index is accepted. It sits between interrupt- or event-source lines and a single consumer that services one source per transaction.

---
 rtl/prio_enc_pend.sv | 117 +++++++++++
 tb/tb_prio_enc_pend.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_pend.sv
// Sticky-pending priority encoder with a one-entry valid/ready output stage.
// Define PRIO_ENC_PEND_RR_EN for round-robin selection; default is highest-index-first.
module prio_enc_pend #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [W-1:0] q,
    output logic         v,
    input  logic         ready,
    output logic [N-1:0] pend,
    output logic         coal
);

    logic [N-1:0] r_pend;
    logic [W-1:0] r_q;
    logic         r_v;
    logic         r_coal;

    logic [N-1:0] w_elig;
    logic         w_any;
    logic [W-1:0] w_sel;
    logic         w_load;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pres;

`ifdef PRIO_ENC_PEND_RR_EN
    logic [W-1:0] r_last;
`endif

    assign w_elig = r_pend & ~mask;
    assign w_any  = |w_elig;
    assign w_load = !r_v || ready;

`ifdef PRIO_ENC_PEND_RR_EN
    // Descending search starting one below the last loaded index, wrapping to N-1.
    always_comb begin
        int start;
        int idx;
        logic found;
        w_sel = '0;
        found = 1'b0;
        start = (r_last == '0) ? int'(N) - 1 : int'(r_last) - 1;
        idx   = 0;
        for (int j = 0; j < int'(N); j++) begin
            idx = start - j;
            if (idx < 0) begin
                idx = idx + int'(N);
            end
            if (!found && w_elig[idx]) begin
                w_sel = W'(idx);
                found = 1'b1;
            end
        end
    end
`else
    // Highest eligible index wins: later loop iterations override earlier ones.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_elig[i]) begin
                w_sel = W'(i);
            end
        end
    end
`endif

    // One-hot decodes of the index being loaded and the index currently presented.
    always_comb begin
        w_clr  = '0;
        w_pres = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_load && w_any && (w_sel == W'(i))) begin
                w_clr[i] = 1'b1;
            end
            if (r_v && (r_q == W'(i))) begin
                w_pres[i] = 1'b1;
            end
        end
    end

    // A req coinciding with its own load re-arms the pending bit as a fresh event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_q    <= '0;
            r_v    <= 1'b0;
            r_coal <= 1'b0;
`ifdef PRIO_ENC_PEND_RR_EN
            r_last <= '0;
`endif
        end else begin
            r_pend <= (r_pend & ~w_clr) | req;
            r_coal <= |(req & (r_pend | w_pres | w_clr));
            if (w_load) begin
                r_v <= w_any;
                if (w_any) begin
                    r_q <= w_sel;
                end
            end
`ifdef PRIO_ENC_PEND_RR_EN
            if (w_load && w_any) begin
                r_last <= w_sel;
            end
`endif
        end
    end

    assign q    = r_q;
    assign v    = r_v;
    assign pend = r_pend;
    assign coal = r_coal;

endmodule

// File: tb/tb_prio_enc_pend.sv
// Directed-vector bench for prio_enc_pend with N=8; follows PRIO_ENC_PEND_RR_EN if defined.
module tb_prio_enc_pend;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic [2:0] q;
    logic       v;
    logic       ready;
    logic [7:0] pend;
    logic       coal;

    int vecs;
    int errs;

    prio_enc_pend #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .mask  (mask),
        .q     (q),
        .v     (v),
        .ready (ready),
        .pend  (pend),
        .coal  (coal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        mask  = '0;
        ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if ({v, q, pend, coal} !== 13'h0) begin errs++; $display("FAIL reset_state: got v=%0b q=%0d pend=%0h coal=%0b expected all 0", v, q, pend, coal); end
        ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            vecs++; if (v !== 1'b0 || q !== 3'd0 || pend !== 8'h00) begin errs++; $display("FAIL idle_cycle%0d: got v=%0b q=%0d pend=%0h expected v=0 q=0 pend=00", c, v, q, pend); end
        end
    endtask

    task automatic test_pulse();
        logic [2:0] exp_q [3];
        exp_q[0] = 3'd6; exp_q[1] = 3'd2; exp_q[2] = 3'd0;
        do_reset();
        ready = 1'b1;
        req   = 8'b0100_0101;
        step();
        req = '0;
        vecs++; if (pend !== 8'h45 || v !== 1'b0) begin errs++; $display("FAIL pulse_capture: got pend=%0h v=%0b expected pend=45 v=0", pend, v); end
        for (int k = 0; k < 3; k++) begin
            step();
            vecs++; if (v !== 1'b1 || q !== exp_q[k]) begin errs++; $display("FAIL pulse_grant%0d: got v=%0b q=%0d expected v=1 q=%0d", k, v, q, exp_q[k]); end
        end
        step();
        vecs++; if (v !== 1'b0 || pend !== 8'h00) begin errs++; $display("FAIL pulse_drain: got v=%0b pend=%0h expected v=0 pend=00", v, pend); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h20;
        step();
        req = '0;
        step();
        vecs++; if (v !== 1'b1 || q !== 3'd5) begin errs++; $display("FAIL bp_present5: got v=%0b q=%0d expected v=1 q=5", v, q); end
        req = 8'h80;
        step();
        req = '0;
        vecs++; if (v !== 1'b1 || q !== 3'd5 || pend !== 8'h80) begin errs++; $display("FAIL bp_hold: got v=%0b q=%0d pend=%0h expected v=1 q=5 pend=80", v, q, pend); end
        step();
        vecs++; if (v !== 1'b1 || q !== 3'd5) begin errs++; $display("FAIL bp_hold2: got v=%0b q=%0d expected v=1 q=5", v, q); end
        ready = 1'b1;
        step();
        vecs++; if (v !== 1'b1 || q !== 3'd7 || pend[5] !== 1'b0) begin errs++; $display("FAIL bp_release: got v=%0b q=%0d pend=%0h expected v=1 q=7 pend[5]=0", v, q, pend); end
        step();
        vecs++; if (v !== 1'b0 || pend !== 8'h00) begin errs++; $display("FAIL bp_empty: got v=%0b pend=%0h expected v=0 pend=00", v, pend); end
    endtask

    task automatic test_coalesce();
        do_reset();
        req = 8'h20;
        step();
        req = '0;
        step();
        req = 8'h08;
        step();
        req = '0;
        vecs++; if (coal !== 1'b0 || pend !== 8'h08) begin errs++; $display("FAIL coal_first: got coal=%0b pend=%0h expected coal=0 pend=08", coal, pend); end
        step();
        vecs++; if (coal !== 1'b0) begin errs++; $display("FAIL coal_gap: got coal=%0b expected 0", coal); end
        req = 8'h08;
        step();
        req = '0;
        vecs++; if (coal !== 1'b1 || pend !== 8'h08) begin errs++; $display("FAIL coal_hit: got coal=%0b pend=%0h expected coal=1 pend=08", coal, pend); end
        step();
        vecs++; if (coal !== 1'b0) begin errs++; $display("FAIL coal_pulse_len: got coal=%0b expected 0", coal); end
        ready = 1'b1;
        step();
        vecs++; if (v !== 1'b1 || q !== 3'd3) begin errs++; $display("FAIL coal_grant3: got v=%0b q=%0d expected v=1 q=3", v, q); end
        step();
        vecs++; if (v !== 1'b0 || pend !== 8'h00) begin errs++; $display("FAIL coal_single_grant: got v=%0b pend=%0h expected v=0 pend=00", v, pend); end
        step();
        vecs++; if (v !== 1'b0) begin errs++; $display("FAIL coal_no_regrant: got v=%0b expected 0", v); end
    endtask

    task automatic test_mask();
        do_reset();
        mask = 8'h80;
        req  = 8'h82;
        step();
        req = '0;
        vecs++; if (pend !== 8'h82 || v !== 1'b0) begin errs++; $display("FAIL mask_capture: got pend=%0h v=%0b expected pend=82 v=0", pend, v); end
        ready = 1'b1;
        step();
        vecs++; if (v !== 1'b1 || q !== 3'd1 || pend !== 8'h80) begin errs++; $display("FAIL mask_grant1: got v=%0b q=%0d pend=%0h expected v=1 q=1 pend=80", v, q, pend); end
        step();
        vecs++; if (v !== 1'b0 || q !== 3'd1 || pend !== 8'h80) begin errs++; $display("FAIL mask_blocked: got v=%0b q=%0d pend=%0h expected v=0 q=1 pend=80", v, q, pend); end
        mask = '0;
        step();
        vecs++; if (v !== 1'b1 || q !== 3'd7) begin errs++; $display("FAIL mask_unmask: got v=%0b q=%0d expected v=1 q=7", v, q); end
        step();
        vecs++; if (v !== 1'b0) begin errs++; $display("FAIL mask_drain: got v=%0b expected 0", v); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'hFF;
        step();
        step();
        vecs++; if (v !== 1'b1 || pend !== 8'hFF || coal !== 1'b1) begin errs++; $display("FAIL midrst_setup: got v=%0b pend=%0h coal=%0b expected v=1 pend=ff coal=1", v, pend, coal); end
        rst   = 1'b1;
        req   = 8'h01;
        ready = 1'b1;
        step();
        vecs++; if ({v, q, pend, coal} !== 13'h0) begin errs++; $display("FAIL midrst_clear: got v=%0b q=%0d pend=%0h coal=%0b expected all 0", v, q, pend, coal); end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_q [4];
`ifdef PRIO_ENC_PEND_RR_EN
        exp_q[0] = 3'd3; exp_q[1] = 3'd0; exp_q[2] = 3'd3; exp_q[3] = 3'd0;
`else
        exp_q[0] = 3'd3; exp_q[1] = 3'd3; exp_q[2] = 3'd3; exp_q[3] = 3'd3;
`endif
        do_reset();
        ready = 1'b1;
        req   = 8'b0000_1001;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            vecs++; if (v !== 1'b1 || q !== exp_q[k]) begin errs++; $display("FAIL b2b_grant%0d: got v=%0b q=%0d expected v=1 q=%0d", k, v, q, exp_q[k]); end
        end
        req = '0;
    endtask

    initial begin
        vecs  = 0;
        errs  = 0;
        rst   = 1'b1;
        req   = '0;
        mask  = '0;
        ready = 1'b0;
        test_reset();
        test_pulse();
        test_backpressure();
        test_coalesce();
        test_mask();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
